// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NREQ requesters, with a single
// outstanding transaction, response routing back to the issuer and a stuck-access watchdog.
module mem_port_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned AW        = 32,
  parameter int unsigned TO_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*4-1:0]  req_we,
  input  logic [NREQ*32-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               m_oe,
  output logic [3:0]         m_we,
  output logic [AW-1:0]      m_addr,
  output logic [31:0]        m_wdata,
  input  logic               m_ready,
  input  logic               m_valid,
  input  logic [31:0]        m_rdata,
  output logic [7:0]         late_cnt
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NREQ - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TO_CYCLES - 1);
  localparam logic [IdxW:0]   NreqW   = (IdxW + 1)'(NREQ);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CntW-1:0] to_cnt_q, to_cnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic [7:0]      late_cnt_q, late_cnt_d;

  logic            arb_found;
  logic [IdxW-1:0] arb_idx;
  logic [IdxW:0]   cand_w;
  logic            complete;
  logic            timeout;
  logic            late_pulse;

  // Rotating priority: scan last_grant+1, +2, ... wrapping at NREQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand_w    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand_w = {1'b0, last_grant_q} + (IdxW + 1)'(k);
      if (cand_w >= NreqW) begin
        cand_w = cand_w - NreqW;
      end
      if (!arb_found && req_valid[cand_w[IdxW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand_w[IdxW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst && (state_q == StIdle) && arb_found) begin
      req_ready[arb_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_idx_d    = gnt_idx_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    to_cnt_d     = to_cnt_q;
    rsp_valid_d  = '0;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    late_cnt_d   = late_cnt_q;
    complete     = 1'b0;
    timeout      = 1'b0;
    late_pulse   = 1'b0;

    case (state_q)
      StIdle: begin
        late_pulse = m_valid;
        if (arb_found) begin
          state_d      = StIssue;
          gnt_idx_d    = arb_idx;
          last_grant_d = arb_idx;
          addr_d       = req_addr[arb_idx*AW +: AW];
          we_d         = req_we[arb_idx*4 +: 4];
          wdata_d      = req_wdata[arb_idx*32 +: 32];
          to_cnt_d     = '0;
        end
      end
      StIssue: begin
        if (m_ready && m_valid) begin
          complete = 1'b1;
        end else begin
          // A completion while the request is still unaccepted cannot belong to it.
          late_pulse = m_valid;
          if (to_cnt_q == CntMax) begin
            timeout = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + CntW'(1);
            if (m_ready) begin
              state_d = StWait;
            end
          end
        end
      end
      StWait: begin
        if (m_valid) begin
          complete = 1'b1;
        end else if (to_cnt_q == CntMax) begin
          timeout = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A real completion on the limit cycle takes precedence over the watchdog.
    if (complete) begin
      rsp_valid_d[gnt_idx_q] = 1'b1;
      rsp_rdata_d            = m_rdata;
      state_d                = StIdle;
    end else if (timeout) begin
      rsp_valid_d[gnt_idx_q] = 1'b1;
      rsp_err_d              = 1'b1;
      rsp_rdata_d            = ERR_DATA;
      state_d                = StIdle;
    end

    if (late_pulse && (late_cnt_q != 8'hFF)) begin
      late_cnt_d = late_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= LastIdx;
      gnt_idx_q    <= '0;
      addr_q       <= '0;
      we_q         <= '0;
      wdata_q      <= '0;
      to_cnt_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      late_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_idx_q    <= gnt_idx_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      to_cnt_q     <= to_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      late_cnt_q   <= late_cnt_d;
    end
  end

  assign m_oe      = (state_q == StIssue);
  assign m_we      = we_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign late_cnt  = late_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 32;
  localparam int TO   = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*4-1:0]   req_we;
  logic [NREQ*32-1:0]  req_wdata;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic                m_oe;
  logic [3:0]          m_we;
  logic [AW-1:0]       m_addr;
  logic [31:0]         m_wdata;
  logic                m_ready;
  logic                m_valid;
  logic [31:0]         m_rdata;
  logic [7:0]          late_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NREQ     (NREQ),
    .AW       (AW),
    .TO_CYCLES(TO),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_we   (req_we),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .m_oe     (m_oe),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_rdata  (m_rdata),
    .late_cnt (late_cnt)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: one transaction record, outputs derived from the rules.
  bit          md_ok = 1'b0;
  bit          mbusy, macc, mdone;
  int          mowner, mage, mlast, mlate, mg;
  logic [31:0] maddr, mwdata, mrdata;
  logic [3:0]  mwe;
  logic [NREQ-1:0] mrv, mer;
  bit          merr;

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (md_ok) begin
      mg  = pick(req_valid, mlast);
      mer = '0;
      if (rst && !mbusy && mg >= 0) mer[mg] = 1'b1;
      chk("req_ready", req_ready, mer);
      chk("rsp_valid", rsp_valid, mrv);
      chk("rsp_err", rsp_err, merr);
      chk("rsp_rdata", rsp_rdata, mrdata);
      chk("m_oe", m_oe, mbusy && !macc);
      if (mbusy && !macc) begin
        chk("m_addr", m_addr, maddr);
        chk("m_we", m_we, mwe);
        chk("m_wdata", m_wdata, mwdata);
      end
      chk("late_cnt", late_cnt, mlate);
    end
    if (!rst) begin
      mbusy = 0; macc = 0; mage = 0; mlast = NREQ - 1; mrv = '0; merr = 0;
      mrdata = '0; mlate = 0; maddr = '0; mwe = '0; mwdata = '0; mowner = 0;
      md_ok = 1'b1;
    end else if (md_ok) begin
      mrv  = '0;
      merr = 0;
      if (!mbusy) begin
        if (m_valid && mlate < 255) mlate++;
        mg = pick(req_valid, mlast);
        if (mg >= 0) begin
          mbusy = 1; macc = 0; mage = 0; mowner = mg; mlast = mg;
          maddr = req_addr[mg*AW +: AW]; mwe = req_we[mg*4 +: 4];
          mwdata = req_wdata[mg*32 +: 32];
        end
      end else begin
        mdone = macc ? m_valid : (m_ready && m_valid);
        if (!macc && !m_ready && m_valid && mlate < 255) mlate++;
        if (mdone) begin
          mrv[mowner] = 1'b1; mrdata = m_rdata; mbusy = 0;
        end else if (mage == TO - 1) begin
          mrv[mowner] = 1'b1; merr = 1; mrdata = 32'hDEADBEEF; mbusy = 0;
        end else begin
          if (m_ready) macc = 1;
          mage++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_addr = '0; req_we = '0; req_wdata = '0;
    m_ready = 1'b0; m_valid = 1'b0; m_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  int gq[$];
  int rq[$];
  int exp_order[5] = '{0, 1, 2, 0, 1};

  initial begin
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_m_oe", m_oe, 0);
    chk("reset_late", late_cnt, 0);
    rst = 1'b1;

    // Single read from the CPU port.
    req_addr[1*AW +: AW] = 32'h100;
    req_valid = 3'b010;
    settle();
    chk("t1_grant", req_ready, 3'b010);
    step();
    req_valid = '0; m_ready = 1'b1;
    settle();
    chk("t1_moe", m_oe, 1);
    chk("t1_addr", m_addr, 32'h100);
    step();
    m_ready = 1'b0;
    settle();
    chk("t1_wait_moe", m_oe, 0);
    step();
    m_valid = 1'b1; m_rdata = 32'h12345678;
    step();
    m_valid = 1'b0;
    settle();
    chk("t1_rsp_valid", rsp_valid, 3'b010);
    chk("t1_rdata", rsp_rdata, 32'h12345678);
    chk("t1_err", rsp_err, 0);
    step();
    chk("t1_rsp_once", rsp_valid, 0);

    // Contention with a one-cycle memory.
    do_reset();
    for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = 32'h1000 * (i + 1);
    req_valid = 3'b111;
    for (int c = 0; c < 11; c++) begin
      m_ready = m_oe; m_valid = m_oe; m_rdata = $urandom;
      settle();
      if (req_ready != 0) gq.push_back(idx_of(req_ready));
      if (rsp_valid != 0) rq.push_back(idx_of(rsp_valid));
      step();
    end
    chk("t2_ngrant", gq.size(), 6);
    chk("t2_nrsp", rq.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < gq.size()) chk("t2_grant_order", gq[k], exp_order[k]);
      if (k < rq.size()) chk("t2_rsp_route", rq[k], exp_order[k]);
    end

    // Write held under backpressure.
    do_reset();
    req_addr[2*AW +: AW] = 32'h200; req_we[8 +: 4] = 4'hF;
    req_wdata[64 +: 32] = 32'hCAFEBABE; req_valid = 3'b100;
    settle();
    chk("t3_grant", req_ready, 3'b100);
    step();
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      m_ready = (c == 3); m_valid = (c == 3);
      settle();
      chk("t3_moe", m_oe, 1);
      chk("t3_addr", m_addr, 32'h200);
      chk("t3_wdata", m_wdata, 32'hCAFEBABE);
      chk("t3_we", m_we, 4'hF);
      step();
    end
    m_ready = 1'b0; m_valid = 1'b0;
    settle();
    chk("t3_rsp_valid", rsp_valid, 3'b100);
    chk("t3_err", rsp_err, 0);

    // Watchdog timeout, then a late completion.
    do_reset();
    req_addr[0 +: AW] = 32'h40; req_valid = 3'b001;
    settle();
    chk("t4_grant", req_ready, 3'b001);
    step();
    req_valid = '0; m_ready = 1'b1;
    settle();
    chk("t4_moe", m_oe, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      m_ready = 1'b0;
      settle();
      if (k < 8) begin
        chk("t4_no_rsp_yet", rsp_valid, 0);
      end else begin
        chk("t4_rsp_valid", rsp_valid, 3'b001);
        chk("t4_err", rsp_err, 1);
        chk("t4_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("t4_moe_off", m_oe, 0);
      end
    end
    m_valid = 1'b1;
    step();
    m_valid = 1'b0;
    settle();
    chk("t4_late_cnt", late_cnt, 1);
    chk("t4_late_no_rsp", rsp_valid, 0);

    // Same-cycle accept and complete.
    do_reset();
    req_addr[1*AW +: AW] = 32'h300; req_valid = 3'b010;
    settle();
    chk("t5_grant", req_ready, 3'b010);
    step();
    req_valid = '0; m_ready = 1'b1; m_valid = 1'b1; m_rdata = 32'hA5A55A5A;
    settle();
    chk("t5_moe", m_oe, 1);
    step();
    m_ready = 1'b0; m_valid = 1'b0;
    settle();
    chk("t5_rsp_valid", rsp_valid, 3'b010);
    chk("t5_rdata", rsp_rdata, 32'hA5A55A5A);
    chk("t5_moe_off", m_oe, 0);

    // Reset while waiting on memory.
    req_valid = 3'b010;
    step();
    req_valid = '0; m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    settle();
    chk("t6_in_wait", m_oe, 0);
    rst = 1'b0;
    step();
    settle();
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_rdata", rsp_rdata, 0);
    chk("t6_err", rsp_err, 0);
    chk("t6_moe", m_oe, 0);
    chk("t6_addr", m_addr, 0);
    rst = 1'b1;
    req_valid = 3'b101;
    settle();
    chk("t6_grant0", req_ready, 3'b001);
    step();
    req_valid = '0; m_ready = 1'b1; m_valid = 1'b1;
    step();
    m_ready = 1'b0; m_valid = 1'b0;
    settle();
    chk("t6_rsp0", rsp_valid, 3'b001);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_addr[i*AW +: AW]  = $urandom;
        req_we[i*4 +: 4]      = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        req_wdata[i*32 +: 32] = $urandom;
      end
      m_ready = ($urandom_range(0, 1) == 1);
      m_valid = ($urandom_range(0, 3) == 0);
      m_rdata = $urandom;
      rst     = ($urandom_range(0, 299) != 0);
      step();
    end
    clear_inputs();
    rst = 1'b1;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
